// File: rtl/run_seq_pkg.sv
// Shared types, default widths and helpers for the run_sequencer slice.
package run_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_CLR = 3'd2,
    RUN      = 3'd3,
    NEXT     = 3'd4
  } run_seq_state_e;

  localparam int DEF_NUM_PROGS = 3;
  localparam int DEF_START_CYC = 2;
  localparam int DEF_CYC_W     = 16;
  localparam int DEF_TIMEOUT   = 65535;

  // Bits needed to encode 0..value-1, never less than one bit
  function automatic int clog2_min1(input int value);
    int width_v;
    width_v = 1;
    while ((64'd1 << width_v) < 64'(value)) begin
      width_v = width_v + 1;
    end
    return width_v;
  endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// Handshake and diagnostic bundle between the launch sequencer and its
// environment (TopLevel core Start/done plus the cycle-count read port).
interface run_sequencer_if
  import run_seq_pkg::*;
#(
  parameter int NUM_PROGS = DEF_NUM_PROGS,
  parameter int CYC_W     = DEF_CYC_W
);
  localparam int IDX_W = clog2_min1(NUM_PROGS);

  logic             go;
  logic             core_done;
  logic             start;
  logic [IDX_W-1:0] prog_idx;
  logic             busy;
  logic             seq_done;
  logic [IDX_W-1:0] cyc_rd_idx;
  logic [CYC_W-1:0] cyc_rd_data;
  logic             timeout_err;

  // Environment side: requests runs, returns core done, reads counts
  modport master (
    output go, core_done, cyc_rd_idx,
    input  start, prog_idx, busy, seq_done, cyc_rd_data, timeout_err
  );

  // Sequencer side
  modport slave (
    input  go, core_done, cyc_rd_idx,
    output start, prog_idx, busy, seq_done, cyc_rd_data, timeout_err
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register: clear, saturating increment, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end
  end

  assign count = count_r;

endmodule

// File: rtl/run_sequencer.sv
// Launches NUM_PROGS programs on the TopLevel core back to back from one go
// request and records cycles-to-done for each program.
// Optional watchdog: define RUN_SEQ_TIMEOUT_EN to abort a hung program after
// TIMEOUT cycles in WAIT_CLR+RUN (count forced to all-ones, sticky flag).
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int NUM_PROGS = DEF_NUM_PROGS,
  parameter int START_CYC = DEF_START_CYC,
  parameter int CYC_W     = DEF_CYC_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input logic           clk,
  input logic           reset,
  run_sequencer_if.slave sif
);

  localparam int                IDX_W    = clog2_min1(NUM_PROGS);
  localparam int                LC_W     = 4;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PROGS - 1);

  if ((START_CYC < 1) || (START_CYC > 15) || (TIMEOUT < 1) || (NUM_PROGS < 1)) begin : g_bad_cfg
    $error("run_sequencer: illegal parameter set");
  end

  run_seq_state_e      state_r;
  logic                start_r;
  logic                busy_r;
  logic                seq_done_r;
  logic [IDX_W-1:0]    prog_idx_r;
  logic [LC_W-1:0]     launch_cnt_r;
  logic                go_acc_s;
  logic                timeout_s;
  logic                timeout_err_s;
  logic [NUM_PROGS-1:0] forced_s;
  logic [CYC_W-1:0]    cnt_s [NUM_PROGS];
  logic [CYC_W-1:0]    rd_data_s;

  assign go_acc_s = (state_r == IDLE) && sif.go;

  // One saturating cycle counter per program, cleared by an accepted go
  for (genvar gi = 0; gi < NUM_PROGS; gi++) begin : g_cnt
    logic inc_s;
    assign inc_s = (state_r == RUN) && !sif.core_done && (prog_idx_r == IDX_W'(gi));
    sat_counter #(.W(CYC_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (go_acc_s),
      .inc   (inc_s),
      .count (cnt_s[gi])
    );
  end

`ifdef RUN_SEQ_TIMEOUT_EN
  localparam int WD_W = clog2_min1(TIMEOUT + 1);

  logic [WD_W-1:0]      wd_cnt_s;
  logic                 wd_active_s;
  logic                 timeout_err_r;
  logic [NUM_PROGS-1:0] forced_r;

  assign wd_active_s = (state_r == WAIT_CLR) || (state_r == RUN);

  sat_counter #(.W(WD_W)) u_wd (
    .clk   (clk),
    .reset (reset),
    .clr   (!wd_active_s),
    .inc   (wd_active_s),
    .count (wd_cnt_s)
  );

  // A genuine done in the final watchdog cycle counts as normal completion
  assign timeout_s = wd_active_s && (wd_cnt_s == WD_W'(TIMEOUT - 1))
                     && !((state_r == RUN) && sif.core_done);

  // Sticky timeout flag and per-program "count forced to all-ones" marks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_err_r <= 1'b0;
      forced_r      <= '0;
    end else if (go_acc_s) begin
      timeout_err_r <= 1'b0;
      forced_r      <= '0;
    end else if (timeout_s) begin
      timeout_err_r <= 1'b1;
      for (int i = 0; i < NUM_PROGS; i++) begin
        if (prog_idx_r == IDX_W'(i)) begin
          forced_r[i] <= 1'b1;
        end
      end
    end
  end

  assign timeout_err_s = timeout_err_r;
  assign forced_s      = forced_r;
`else
  assign timeout_s     = 1'b0;
  assign timeout_err_s = 1'b0;
  assign forced_s      = '0;
`endif

  // Sequencer FSM with registered start/busy/seq_done/prog_idx
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      start_r      <= 1'b0;
      busy_r       <= 1'b0;
      seq_done_r   <= 1'b0;
      prog_idx_r   <= '0;
      launch_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (sif.go) begin
            state_r      <= LAUNCH;
            start_r      <= 1'b1;
            busy_r       <= 1'b1;
            seq_done_r   <= 1'b0;
            prog_idx_r   <= '0;
            launch_cnt_r <= '0;
          end
        end
        LAUNCH: begin
          // core_done is deliberately ignored while Start is being held
          if (launch_cnt_r == LC_W'(START_CYC - 1)) begin
            state_r <= WAIT_CLR;
            start_r <= 1'b0;
          end else begin
            launch_cnt_r <= launch_cnt_r + LC_W'(1);
          end
        end
        WAIT_CLR: begin
          // Wait out a stale done left over from the previous program
          if (timeout_s) begin
            state_r <= NEXT;
          end else if (!sif.core_done) begin
            state_r <= RUN;
          end
        end
        RUN: begin
          if (sif.core_done || timeout_s) begin
            state_r <= NEXT;
          end
        end
        NEXT: begin
          if (prog_idx_r == LAST_IDX) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            seq_done_r <= 1'b1;
          end else begin
            state_r      <= LAUNCH;
            start_r      <= 1'b1;
            prog_idx_r   <= prog_idx_r + IDX_W'(1);
            launch_cnt_r <= '0;
          end
        end
        default: begin
          state_r <= IDLE;
          start_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational diagnostic read; out-of-range index reads zero
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      rd_data_s = (sif.cyc_rd_idx == IDX_W'(i))
                  ? (forced_s[i] ? {CYC_W{1'b1}} : cnt_s[i])
                  : rd_data_s;
    end
  end

  assign sif.start       = start_r;
  assign sif.busy        = busy_r;
  assign sif.seq_done    = seq_done_r;
  assign sif.prog_idx    = prog_idx_r;
  assign sif.cyc_rd_data = rd_data_s;
  assign sif.timeout_err = timeout_err_s;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: table vectors, randomized sequences
// against a behavioural core/count model, and reset/watchdog corner cases.
// A second 1-program, 4-bit instance shares go/core_done to cover
// NUM_PROGS=1 and counter saturation.
module tb_run_sequencer;
  import run_seq_pkg::*;

  localparam int NP   = 3;
  localparam int SC   = 2;
  localparam int CW   = 16;
  localparam int TO   = 100;
  localparam int NP_S = 1;
  localparam int CW_S = 4;

  typedef struct {
    int hold    [NP];
    int len     [NP];
    bit glitch;
    bit gopulse;
    int exp_cnt [NP];
    int exp_small;
  } seq_vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  run_sequencer_if #(.NUM_PROGS(NP),   .CYC_W(CW))   sif ();
  run_sequencer_if #(.NUM_PROGS(NP_S), .CYC_W(CW_S)) sif_s ();

  assign sif_s.go        = sif.go;
  assign sif_s.core_done = sif.core_done;

  run_sequencer #(.NUM_PROGS(NP), .START_CYC(SC), .CYC_W(CW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  run_sequencer #(.NUM_PROGS(NP_S), .START_CYC(SC), .CYC_W(CW_S), .TIMEOUT(TO)) dut_s (
    .clk   (clk),
    .reset (reset),
    .sif   (sif_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a program's recorded count is its low-done RUN cycles, clipped
  function automatic int sat_ref(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  function automatic seq_vec_t mk(input int h0, h1, h2, n0, n1, n2,
                                  input bit g, input bit gp,
                                  input int e0, e1, e2, es);
    seq_vec_t v;
    v.hold[0] = h0; v.hold[1] = h1; v.hold[2] = h2;
    v.len[0]  = n0; v.len[1]  = n1; v.len[2]  = n2;
    v.glitch  = g;  v.gopulse = gp;
    v.exp_cnt[0] = e0; v.exp_cnt[1] = e1; v.exp_cnt[2] = e2;
    v.exp_small  = es;
    return v;
  endfunction

  // Core model for one program: done held high h cycles after start falls,
  // then low for n RUN cycles, then high (stays high as a stale done).
  task automatic run_prog(input int p, input int h, input int n,
                          input bit glitch, input bit gopulse, input bit hang);
    int guard;
    int hi;
    guard = 0;
    while (sif.start !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("p%0d_start_seen", p), sif.start, 1);
    hi = 0;
    while (sif.start === 1'b1 && hi < 40) begin
      chk($sformatf("p%0d_launch_idx", p), sif.prog_idx, p);
      chk($sformatf("p%0d_launch_busy", p), sif.busy, 1);
      sif.core_done = glitch ? 1'($urandom_range(0, 1)) : ((h == 0) ? 1'b0 : 1'b1);
      hi++;
      @(negedge clk);
    end
    chk($sformatf("p%0d_start_width", p), hi, SC);
    if (hang) begin
      sif.core_done = 1'b0;
    end else begin
      sif.core_done = (h > 0);
      for (int i = 1; i <= h + 1 + n; i++) begin
        @(negedge clk);
        sif.core_done = (i < h) || (i == h + 1 + n);
        sif.go = gopulse && (p == 0) && (i == h + 1) && (n > 0);
      end
    end
  endtask

  task automatic read_counts(input seq_vec_t v, input string tag);
    for (int p = 0; p < NP; p++) begin
      sif.cyc_rd_idx = 2'(p);
      #1;
      chk($sformatf("%s_count%0d", tag, p), sif.cyc_rd_data, v.exp_cnt[p]);
    end
    sif.cyc_rd_idx = 2'd3;
    sif_s.cyc_rd_idx = 1'b1;
    #1;
    chk({tag, "_oob_read"}, sif.cyc_rd_data, 0);
    chk({tag, "_small_oob_read"}, sif_s.cyc_rd_data, 0);
    sif.cyc_rd_idx = 2'd0;
    sif_s.cyc_rd_idx = 1'b0;
    #1;
    chk({tag, "_small_count"}, sif_s.cyc_rd_data, v.exp_small);
    chk({tag, "_small_seq_done"}, sif_s.seq_done, 1);
    chk({tag, "_small_busy"}, sif_s.busy, 0);
  endtask

  task automatic run_seq(input seq_vec_t v, input string tag);
    @(negedge clk);
    sif.go = 1'b1;
    @(negedge clk);
    sif.go = 1'b0;
    chk({tag, "_go_to_start"}, sif.start, 1);
    chk({tag, "_busy_on_go"}, sif.busy, 1);
    chk({tag, "_seq_done_cleared"}, sif.seq_done, 0);
    for (int p = 0; p < NP; p++) begin
      run_prog(p, v.hold[p], v.len[p], v.glitch, v.gopulse, 1'b0);
    end
    @(negedge clk);
    chk({tag, "_next_busy"}, sif.busy, 1);
    chk({tag, "_next_seq_done"}, sif.seq_done, 0);
    @(negedge clk);
    chk({tag, "_end_seq_done"}, sif.seq_done, 1);
    chk({tag, "_end_busy"}, sif.busy, 0);
    chk({tag, "_end_start"}, sif.start, 0);
    chk({tag, "_timeout_err"}, sif.timeout_err, 0);
    read_counts(v, tag);
  endtask

  seq_vec_t vecs [4];
  seq_vec_t rv;
  int       guard;
  int       hi_cnt;

  initial begin
    sif.go = 1'b0;
    sif.core_done = 1'b1;
    sif.cyc_rd_idx = 2'd0;
    sif_s.cyc_rd_idx = 1'b0;

    vecs[0] = mk(0, 0, 0, 40, 55, 70, 1'b0, 1'b0, 40, 55, 70, 15);
    vecs[1] = mk(5, 0, 2, 30, 12, 9,  1'b1, 1'b1, 30, 12, 9,  15);
    vecs[2] = mk(0, 1, 0, 15, 1, 3,   1'b0, 1'b1, 15, 1, 3,   15);
    vecs[3] = mk(3, 0, 6, 16, 0, 2,   1'b1, 1'b0, 16, 0, 2,   15);

    // Reset held low for 3 cycles
    repeat (3) @(negedge clk);
    chk("rst_start", sif.start, 0);
    chk("rst_busy", sif.busy, 0);
    chk("rst_seq_done", sif.seq_done, 0);
    chk("rst_prog_idx", sif.prog_idx, 0);
    chk("rst_timeout_err", sif.timeout_err, 0);
    chk("rst_count0", sif.cyc_rd_data, 0);
    reset = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hi_cnt += int'(sif.start === 1'b1) + int'(sif.busy === 1'b1);
    end
    chk("idle_no_start", hi_cnt, 0);

    // Table-driven sequences
    for (int k = 0; k < 4; k++) begin
      run_seq(vecs[k], $sformatf("vec%0d", k));
    end

`ifdef RUN_SEQ_TIMEOUT_EN
    // Program 0 never raises done: watchdog aborts it, sequence continues
    @(negedge clk);
    sif.go = 1'b1;
    @(negedge clk);
    sif.go = 1'b0;
    run_prog(0, 0, 0, 1'b0, 1'b0, 1'b1);
    guard = 0;
    while (sif.start !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("wd_relaunch_cycles", guard, TO + 1);
    run_prog(1, 0, 20, 1'b0, 1'b0, 1'b0);
    run_prog(2, 0, 20, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("wd_seq_done", sif.seq_done, 1);
    chk("wd_timeout_err", sif.timeout_err, 1);
    chk("wd_small_timeout_err", sif_s.timeout_err, 1);
    rv = mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 32'hFFFF, 20, 20, 15);
    read_counts(rv, "wd");
`endif

    // Randomized sequences checked against the count model
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < NP; p++) begin
        rv.hold[p]    = $urandom_range(0, 6);
        rv.len[p]     = $urandom_range(0, 60);
        rv.exp_cnt[p] = sat_ref(rv.len[p], CW);
      end
      rv.glitch    = 1'($urandom_range(0, 1));
      rv.gopulse   = 1'($urandom_range(0, 1));
      rv.exp_small = sat_ref(rv.len[0], CW_S);
      run_seq(rv, $sformatf("rnd%0d", k));
    end

    // Reset asserted during RUN of program 1
    @(negedge clk);
    sif.go = 1'b1;
    @(negedge clk);
    sif.go = 1'b0;
    run_prog(0, 0, 10, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (sif.start !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_p1_idx", sif.prog_idx, 1);
    guard = 0;
    while (sif.start === 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    sif.core_done = 1'b0;
    repeat (4) @(negedge clk);
    sif.cyc_rd_idx = 2'd0;
    #1;
    chk("mid_count0_before", sif.cyc_rd_data, 10);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_start", sif.start, 0);
    chk("mid_rst_busy", sif.busy, 0);
    chk("mid_rst_seq_done", sif.seq_done, 0);
    chk("mid_rst_prog_idx", sif.prog_idx, 0);
    chk("mid_rst_count0", sif.cyc_rd_data, 0);
    chk("mid_rst_small_count", sif_s.cyc_rd_data, 0);
    @(negedge clk);
    sif.core_done = 1'b1;
    reset = 1'b1;

    // Reset during LAUNCH: start must drop without a clock edge
    @(negedge clk);
    sif.go = 1'b1;
    @(negedge clk);
    sif.go = 1'b0;
    chk("launch_start_before_rst", sif.start, 1);
    #2 reset = 1'b0;
    #1;
    chk("launch_rst_start_async", sif.start, 0);
    chk("launch_rst_busy_async", sif.busy, 0);
    @(negedge clk);
    reset = 1'b1;

    // Fresh run after reset restarts from program 0
    run_seq(vecs[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
